// File: rtl/smc_frame_loader.sv
// smc_frame_loader: serial-to-parallel frame loader in front of the
// combinational SMC transistor-evaluation stage. Collects N_TR slots of
// (W, V_GS, V_DS), presents them as packed buses, captures the SMC result
// and emits it with a one-cycle strobe. Truncated frames raise frame_err.
//
// Input handshake: there is no ready. A slot is transferred on every rising
// edge where in_valid=1 and the loader is in IDLE, LOAD or OUT. A slot
// offered during EVAL is dropped and answered by a frame_err pulse.
//
// dbg_state encoding: 0=IDLE, 1=LOAD, 2=EVAL, 3=OUT.
module smc_frame_loader #(
    parameter int N_TR = 6,
    parameter int DW   = 3,
    parameter int OW   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [DW-1:0]        W,
    input  logic [DW-1:0]        V_GS,
    input  logic [DW-1:0]        V_DS,
    output logic [1:0]           smc_mode,
    output logic [DW*N_TR-1:0]   smc_W,
    output logic [DW*N_TR-1:0]   smc_V_GS,
    output logic [DW*N_TR-1:0]   smc_V_DS,
    input  logic [OW-1:0]        smc_out_n,
    output logic                 out_valid,
    output logic [OW-1:0]        out_n,
    output logic                 frame_err,
    output logic [1:0]           dbg_state
);

    localparam int             CW   = (N_TR > 1) ? $clog2(N_TR) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N_TR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [OW-1:0]   result;

    // Control decoded from state for the datapath register block.
    logic            slot_we;   // write slot cnt and, on slot 0, latch mode
    logic            mode_we;
    logic            bus_clr;
    logic            res_we;
    logic            err_set;

    // State and slot-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and datapath control. cnt is always 0 in IDLE and OUT, so
    // "write slot cnt" covers slot 0 of a new frame as well.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        slot_we    = 1'b0;
        mode_we    = 1'b0;
        bus_clr    = 1'b0;
        res_we     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE, OUT: begin
                if (in_valid) begin
                    slot_we    = 1'b1;
                    mode_we    = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    slot_we = 1'b1;
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = EVAL;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    // Frame ended early: drop it and flag the truncation.
                    bus_clr    = 1'b1;
                    err_set    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            EVAL: begin
                res_we     = 1'b1;
                err_set    = in_valid;
                state_next = OUT;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Bus, mode, result and error-strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smc_mode  <= '0;
            smc_W     <= '0;
            smc_V_GS  <= '0;
            smc_V_DS  <= '0;
            result    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_set;
            if (bus_clr) begin
                smc_mode <= '0;
                smc_W    <= '0;
                smc_V_GS <= '0;
                smc_V_DS <= '0;
            end else if (slot_we) begin
                if (mode_we) begin
                    smc_mode <= mode;
                end
                smc_W   [int'(cnt) * DW +: DW] <= W;
                smc_V_GS[int'(cnt) * DW +: DW] <= V_GS;
                smc_V_DS[int'(cnt) * DW +: DW] <= V_DS;
            end
            if (res_we) begin
                result <= smc_out_n;
            end
        end
    end

    // The result is only visible during the single OUT cycle.
    assign out_valid = (state == OUT);
    assign out_n     = out_valid ? result : '0;
    assign dbg_state = state;

endmodule
